m_macinvf: RTL

Parametrised multi-channel inverter with programmable per-channel polarity and a stability (glitch) filter, the successor to the fixed twin-inverter macro. Each channel registers its input, applies a run-time selectable inversion, and only propagates a new level once it has been stable for FILTER consecutive clocks, pulsing a per-channel change strobe. It sits between asynchronous or noisy board-level signals (joystick lines, switch inputs, external strobes) and Slipstream logic clocked by MasterClock.

---
 rtl/m_macinvf.sv | 69 ++++++
 1 files changed

// File: rtl/m_macinvf.sv
// Multi-channel inverter with run-time polarity and a per-channel stability filter.
// A new level reaches Q only after the candidate has differed from Q for FILTER clocks.
module m_macinvf #(
    parameter int WIDTH  = 2,
    parameter int FILTER = 4,
    localparam int CW    = $clog2(FILTER + 1)
) (
    input  logic             MasterClock,
    input  logic             nReset,
    input  logic [WIDTH-1:0] I,
    input  logic             PolLoad,
    input  logic [WIDTH-1:0] PolData,
    output logic [WIDTH-1:0] Pol,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Changed
);

    localparam logic [CW-1:0] CntMax = CW'(FILTER - 1);

    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] pol_q, pol_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] candidate;

    // Any return of the candidate to Q restarts the count, so short glitches never commit.
    always_comb begin
        sample_d  = I;
        pol_d     = PolLoad ? PolData : pol_q;
        out_d     = out_q;
        changed_d = '0;
        cnt_d     = cnt_q;
        candidate = sample_q ^ pol_q;
        for (int n = 0; n < WIDTH; n++) begin
            if (candidate[n] == out_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CntMax) begin
                out_d[n]     = candidate[n];
                cnt_d[n]     = '0;
                changed_d[n] = 1'b1;
            end else begin
                cnt_d[n] = cnt_q[n] + CW'(1);
            end
        end
    end

    always_ff @(posedge MasterClock) begin
        if (!nReset) begin
            sample_q  <= '0;
            pol_q     <= '1;
            out_q     <= '1;
            changed_q <= '0;
            cnt_q     <= '{default: '0};
        end else begin
            sample_q  <= sample_d;
            pol_q     <= pol_d;
            out_q     <= out_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Pol     = pol_q;
    assign Q       = out_q;
    assign Changed = changed_q;

endmodule
